// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the icache-side L2 request arbiter.
package sargantana_icache_pkg;

  // Arbiter FSM states: grant in IDLE, present in REQ, wait for the response in WAIT,
  // and swallow an orphaned response in DRAIN.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  // Owner of the single outstanding transaction.
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_NC = 1'b1
  } owner_t;

  // Low address bits cleared on the way to L2: 32-byte line for refills, 8-byte beat for nc.
  localparam int unsigned LINE_OFF_W = 5;
  localparam int unsigned NC_OFF_W   = 3;

endpackage

// File: rtl/icache_l2_starve_ctr.sv
// Starvation counter and priority select: refill normally wins, but nc is forced through
// once it has lost STARVE_MAX consecutive arbitrations.
module icache_l2_starve_ctr
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,    // an arbitration actually takes place this cycle
  input  logic ic_valid_i,
  input  logic nc_valid_i,
  output logic grant_nc_o   // nc is the winner if arbitration happens
);

  localparam int unsigned          CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Priority select: nc wins when it is alone or when it has been starved long enough.
  assign grant_nc_o = nc_valid_i && (!ic_valid_i || (cnt_q == CNT_MAX));

  // Next count: saturating increment on an nc loss, clear on an nc win or no nc request.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_en_i) begin
      if (nc_valid_i && !grant_nc_o) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/icache_l2_req_arbiter.sv
// Shares the L1-I L2 request port between the icache refill path and the nc fetch buffer.
// One transaction outstanding; responses are routed to their owner, and fetch kills are
// absorbed by draining the orphaned response.
module icache_l2_req_arbiter
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_W    = 40,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TO_W       = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ic_req_valid_i,
  input  logic [PADDR_W-1:0] ic_req_paddr_i,
  output logic               ic_req_ready_o,
  input  logic               nc_req_valid_i,
  input  logic [PADDR_W-1:0] nc_req_paddr_i,
  output logic               nc_req_ready_o,
  input  logic               kill_i,
  output logic               l2_req_valid_o,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  output logic               l2_req_nc_o,
  input  logic               l2_req_ready_i,
  input  logic               l2_resp_valid_i,
  input  logic [LINE_W-1:0]  l2_resp_data_i,
  output logic               ic_resp_valid_o,
  output logic               nc_resp_valid_o,
  output logic [LINE_W-1:0]  resp_data_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam logic [PADDR_W-1:0] LINE_MASK = {{(PADDR_W-LINE_OFF_W){1'b1}}, {LINE_OFF_W{1'b0}}};
  localparam logic [PADDR_W-1:0] NC_MASK   = {{(PADDR_W-NC_OFF_W){1'b1}}, {NC_OFF_W{1'b0}}};

  arb_state_t         state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               kill_pend_q, kill_pend_d;
  logic               ic_resp_q, ic_resp_d;
  logic               nc_resp_q, nc_resp_d;
  logic [LINE_W-1:0]  resp_data_q, resp_data_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               timeout_q, timeout_d;

  logic arb_en;
  logic grant_nc;
  logic ic_ready, nc_ready;
  logic in_wait_drain;

  // An arbitration happens only in IDLE, with no kill, and with something to grant.
  assign arb_en = (state_q == ST_IDLE) && !kill_i && (ic_req_valid_i || nc_req_valid_i);

  icache_l2_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .arb_en_i   (arb_en),
    .ic_valid_i (ic_req_valid_i),
    .nc_valid_i (nc_req_valid_i),
    .grant_nc_o (grant_nc)
  );

  // Next-state and transaction bookkeeping for the request FSM.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    paddr_d     = paddr_q;
    kill_pend_d = kill_pend_q;
    ic_resp_d   = 1'b0;
    nc_resp_d   = 1'b0;
    resp_data_d = resp_data_q;
    ic_ready    = 1'b0;
    nc_ready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        kill_pend_d = 1'b0;
        if (arb_en) begin
          if (grant_nc) begin
            nc_ready = 1'b1;
            owner_d  = OWN_NC;
            paddr_d  = nc_req_paddr_i & NC_MASK;
          end else begin
            ic_ready = 1'b1;
            owner_d  = OWN_IC;
            paddr_d  = ic_req_paddr_i & LINE_MASK;
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // The request stays up even under kill; a kill only redirects where it lands.
        if (l2_req_ready_i) begin
          state_d     = (kill_i || kill_pend_q) ? ST_DRAIN : ST_WAIT;
          kill_pend_d = 1'b0;
        end else if (kill_i) begin
          kill_pend_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (l2_resp_valid_i) begin
          // A kill in the same cycle wins and the response is simply dropped.
          if (!kill_i) begin
            resp_data_d = l2_resp_data_i;
            ic_resp_d   = (owner_q == OWN_IC);
            nc_resp_d   = (owner_q == OWN_NC);
          end
          state_d = ST_IDLE;
        end else if (kill_i) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (l2_resp_valid_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Response timeout: counts while waiting on L2, restarts on entry, sticks once overdue.
  always_comb begin
    in_wait_drain = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    to_cnt_d      = to_cnt_q;
    timeout_d     = timeout_q;
    if ((state_d != state_q) && ((state_d == ST_WAIT) || (state_d == ST_DRAIN))) begin
      to_cnt_d = '0;
    end else if (in_wait_drain && (to_cnt_q != '1)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    if (in_wait_drain && (to_cnt_d == '1)) timeout_d = 1'b1;
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IC;
      paddr_q     <= '0;
      kill_pend_q <= 1'b0;
      ic_resp_q   <= 1'b0;
      nc_resp_q   <= 1'b0;
      resp_data_q <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      paddr_q     <= paddr_d;
      kill_pend_q <= kill_pend_d;
      ic_resp_q   <= ic_resp_d;
      nc_resp_q   <= nc_resp_d;
      resp_data_q <= resp_data_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ic_req_ready_o  = ic_ready;
  assign nc_req_ready_o  = nc_ready;
  assign l2_req_valid_o  = (state_q == ST_REQ);
  assign l2_req_paddr_o  = paddr_q;
  assign l2_req_nc_o     = (owner_q == OWN_NC);
  assign ic_resp_valid_o = ic_resp_q;
  assign nc_resp_valid_o = nc_resp_q;
  assign resp_data_o     = resp_data_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign timeout_o       = timeout_q;

endmodule

// File: doc/icache_l2_req_arbiter.md
Name: icache_l2_req_arbiter

Overview:
- Shares the single L1-instruction-side L2/NoC request port between two requesters:
  - the icache miss/refill path (cacheable, full 256-bit line);
  - the non-cacheable fetch buffer (64-bit beat).
- Keeps exactly one transaction outstanding and routes the response back to its owner.
- Absorbs fetch kills by draining and discarding orphaned responses.
- Sits between the icache/nc fetch buffer and the L2 interface in the core tile.

Parameters:
- PADDR_W, 40, physical address width
- LINE_W, 256, L2 response data width
- STARVE_MAX, 4, consecutive nc arbitration losses before nc is forced to win
- TO_W, 10, timeout counter width; timeout fires at 2^TO_W-1 cycles

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- ic_req_valid_i  in  1  icache refill request
- ic_req_paddr_i  in  PADDR_W  refill address
- ic_req_ready_o  out  1  refill request accepted this cycle
- nc_req_valid_i  in  1  non-cacheable fetch request
- nc_req_paddr_i  in  PADDR_W  nc address
- nc_req_ready_o  out  1  nc request accepted this cycle
- kill_i  in  1  fetch flush (inval_fetch | invalidate_icache)
- l2_req_valid_o  out  1  request to L2
- l2_req_paddr_o  out  PADDR_W  aligned request address
- l2_req_nc_o  out  1  1 = non-cacheable beat, 0 = line refill
- l2_req_ready_i  in  1  L2 accepts request
- l2_resp_valid_i  in  1  L2 response/grant
- l2_resp_data_i  in  LINE_W  response data
- ic_resp_valid_o  out  1  response for refill owner
- nc_resp_valid_o  out  1  response for nc owner
- resp_data_o  out  LINE_W  registered response data (shared)
- busy_o  out  1  state != IDLE
- timeout_o  out  1  sticky: response overdue

Behaviour:
- Reset: every register and output is 0; state = IDLE; starve_cnt = 0; timeout_o = 0. Reset mid-transaction abandons the transaction. No response is ever emitted for it.
- States: IDLE, REQ, WAIT, DRAIN (2-bit encoding).
- Arbitration in IDLE, when ~kill_i and at least one request is valid:
  - Default: refill beats nc.
  - If starve_cnt == STARVE_MAX and nc is valid, nc wins.
  - starve_cnt increments (saturating) when nc is valid and loses. It clears when nc wins or nc is not valid.
  - The winner's ready_o is asserted combinationally in the same cycle. Owner, address and nc flag are latched. Next state is REQ.
- kill_i in IDLE: no grant that cycle; both ready_o = 0.
- Address alignment:
  - refill: paddr[4:0] forced to 0.
  - nc: paddr[2:0] forced to 0.
- REQ:
  - l2_req_valid_o = 1; address and flag are held stable until l2_req_ready_i.
  - The request is never retracted, even on kill.
  - On accept, go to WAIT; if a kill is pending (kill_i now or latched earlier in REQ), go to DRAIN instead.
- WAIT:
  - On l2_resp_valid_i & ~kill_i: latch data into resp_data_o; next cycle pulse the owner's resp_valid_o for 1 cycle; go to IDLE.
  - On kill_i without response: go to DRAIN.
  - On kill_i together with l2_resp_valid_i: kill wins. The response is discarded; go to IDLE.
- DRAIN: on l2_resp_valid_i, discard and go to IDLE. No resp_valid_o.
- Latency:
  - request valid at cycle N (IDLE) → l2_req_valid_o at N+1.
  - l2_resp_valid_i at M → owner resp_valid_o at M+1.
  - Back-to-back: next grant is possible in the cycle the FSM is back in IDLE, i.e. M+1.
- Timeout:
  - Counter runs in WAIT and DRAIN, clears on state entry, and saturates.
  - At all-ones, timeout_o is set and held until reset. State is unaffected.
- resp_data_o holds its last value when no response arrives.
- A response arriving in IDLE or REQ is a protocol error; it is ignored.

Decomposition:
- Shared package (sargantana_icache_pkg): arb_state_t enum, owner_t enum {OWN_IC, OWN_NC}, alignment mask constants.
- Natural sub-module: icache_l2_starve_ctr (saturating starvation counter plus priority select).

Test Plan:
- Single refill: ic_req_paddr_i = 0x80001234; ready @N, l2_req_paddr_o = 0x80001220 nc = 0 @N+1; l2 ready @N+2, resp @N+5 data = D → ic_resp_valid_o = 1 and resp_data_o = D @N+6, nc_resp_valid_o = 0.
- Contention and starvation: both valid every cycle with instant L2 ready/resp → grants IC ×4, then NC once (nc paddr 0x0001000C sent as 0x00010008), then the pattern repeats.
- Kill in WAIT: nc request accepted, kill_i at resp-2 → DRAIN, response dropped, no resp_valid_o, busy_o falls the cycle after the response.
- Kill in REQ with l2_req_ready_i = 0 for 3 cycles → request held stable the whole time, then DRAIN, response discarded.
- Kill coincident with response in WAIT → no resp_valid_o; next queued IC request granted in the following cycle.
- L2 never responds → timeout_o = 1 after 1023 cycles in WAIT. rst_i asserted mid-WAIT → all outputs 0 immediately (asynchronous), and a subsequent request completes normally.
